// File: rtl/prio_req_encoder.sv
// -----------------------------------------------------------------------------
// prio_req_encoder
//
// Collects single-cycle request pulses on N lines and presents them one at a
// time as an encoded index behind a valid/ready output stage.  Requests that
// are not yet presented wait in a pending register.
//
// Arbitration:
//   MODE = 0 : fixed priority, highest index wins.
//   MODE = 1 : round-robin, searching downward from (last-1) mod N with
//              wrap-around from 0 to N-1.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   req_in     [N-1:0] request pulses, one cycle per request
//   out_ready  consumer accepts the presented index
//   out_valid  out_idx holds a valid request
//   out_idx    [W-1:0] presented index (always <= N-1)
//   pending    [N-1:0] registered requests not yet presented
//   busy       out_valid | (|pending)
// -----------------------------------------------------------------------------
module prio_req_encoder #(
    parameter  int N    = 8,
    parameter  int MODE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         busy
);

    logic [W-1:0] last;
    logic [N-1:0] cand;
    logic [N-1:0] sel_oh;
    logic [W-1:0] sel_fixed;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;
    logic         load;
    logic         rr_found;
    int           rr_start;
    int           rr_idx;

    assign cand = pending | req_in;
    // The output register reloads whenever it is empty or being consumed,
    // so a handshake and the next presentation share one edge.
    assign load = !out_valid || out_ready;
    assign busy = out_valid | (|pending);

    // Fixed priority: scanning upward lets the highest set bit win.
    always_comb begin
        sel_fixed = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) sel_fixed = W'(i);
        end
    end

    // Round-robin: start one below the last winner; a reset value of 0 makes
    // the first search begin at N-1, matching fixed-priority order.
    // Index arithmetic is done in int and wrapped by adding N, so it stays
    // within 0..N-1 for non-power-of-two N.
    always_comb begin
        rr_start = (last == '0) ? N - 1 : int'(last) - 1;
        rr_idx   = 0;
        rr_found = 1'b0;
        sel_rr   = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = rr_start - k;
            if (rr_idx < 0) rr_idx = rr_idx + N;
            if (!rr_found && cand[rr_idx[W-1:0]]) begin
                rr_found = 1'b1;
                sel_rr   = rr_idx[W-1:0];
            end
        end
    end

    assign sel = (MODE == 1) ? sel_rr : sel_fixed;

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            pending   <= '0;
            last      <= '0;
        end else if (load) begin
            if (|cand) begin
                out_valid <= 1'b1;
                out_idx   <= sel;
                pending   <= cand & ~sel_oh;
                last      <= sel;
            end else begin
                // out_idx deliberately keeps its last value.
                out_valid <= 1'b0;
                pending   <= '0;
            end
        end else begin
            // Stalled: a new pulse on the presented line becomes a separate
            // pending request; repeats on an already-pending line absorb.
            pending <= pending | req_in;
        end
    end

endmodule

// File: tb/tb_prio_req_encoder.sv
// -----------------------------------------------------------------------------
// tb_prio_req_encoder
//
// Three instances: d0 (N=8, fixed), d1 (N=8, round-robin), d2 (N=5,
// round-robin).  Expected indices are queued when stimulus is applied and
// popped by a per-instance monitor on every output handshake.
// -----------------------------------------------------------------------------
module tb_prio_req_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] r0, r1;
    logic [4:0] r2;
    logic       rdy0, rdy1, rdy2;
    logic       v0, v1, v2;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] p0, p1;
    logic [4:0] p2;
    logic       b0, b1, b2;

    int checks   = 0;
    int failures = 0;
    int q0[$];
    int q1[$];
    int q2[$];

    always #5 clk = ~clk;

    prio_req_encoder #(.N(8), .MODE(0)) d0 (
        .clk(clk), .rst(rst), .req_in(r0), .out_ready(rdy0),
        .out_valid(v0), .out_idx(idx0), .pending(p0), .busy(b0)
    );
    prio_req_encoder #(.N(8), .MODE(1)) d1 (
        .clk(clk), .rst(rst), .req_in(r1), .out_ready(rdy1),
        .out_valid(v1), .out_idx(idx1), .pending(p1), .busy(b1)
    );
    prio_req_encoder #(.N(5), .MODE(1)) d2 (
        .clk(clk), .rst(rst), .req_in(r2), .out_ready(rdy2),
        .out_valid(v2), .out_idx(idx2), .pending(p2), .busy(b2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: sample mid-cycle, ahead of the handshake edge.
    always @(negedge clk) begin
        if (!rst && v0 && rdy0) begin
            if (q0.size() == 0) chk("d0_extra_out", int'(idx0), -1);
            else                chk("d0_idx", int'(idx0), q0.pop_front());
        end
        if (!rst && v1 && rdy1) begin
            if (q1.size() == 0) chk("d1_extra_out", int'(idx1), -1);
            else                chk("d1_idx", int'(idx1), q1.pop_front());
        end
        if (!rst && v2 && rdy2) begin
            if (q2.size() == 0) chk("d2_extra_out", int'(idx2), -1);
            else                chk("d2_idx", int'(idx2), q2.pop_front());
        end
    end

    initial begin
        // ---- reset, with requests asserted that must be discarded
        rst = 1'b1;
        r0 = 8'hFF; r1 = 8'hFF; r2 = 5'h1F;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        tick(2);
        chk("rst_v0", int'(v0), 0);
        chk("rst_idx0", int'(idx0), 0);
        chk("rst_p0", int'(p0), 0);
        chk("rst_b0", int'(b0), 0);
        chk("rst_v1", int'(v1), 0);
        chk("rst_p2", int'(p2), 0);
        r0 = '0; r1 = '0; r2 = '0;
        #1 rst = 1'b0;
        tick();
        chk("post_rst_v0", int'(v0), 0);
        chk("post_rst_v1", int'(v1), 0);
        chk("post_rst_v2", int'(v2), 0);

        // ---- N=5 round-robin: 4 then 0, then idle
        r2 = 5'b10001;
        q2.push_back(4); q2.push_back(0);
        tick();
        chk("n5_first", int'(idx2), 4);
        r2 = '0;
        tick();
        chk("n5_second", int'(idx2), 0);
        tick();
        chk("n5_idle", int'(v2), 0);

        // ---- fixed priority basic: 5, 2, idle
        r0 = 8'b0010_0100;
        q0.push_back(5); q0.push_back(2);
        tick();
        chk("fp_idx5", int'(idx0), 5);
        chk("fp_pend", int'(p0), 8'h04);
        r0 = '0;
        tick();
        chk("fp_idx2", int'(idx0), 2);
        tick();
        chk("fp_v_off", int'(v0), 0);
        chk("fp_busy_off", int'(b0), 0);

        // ---- stall holding 5 while 7 arrives
        rdy0 = 1'b0;
        r0 = 8'h20;
        q0.push_back(5); q0.push_back(7);
        tick();
        chk("stall_v", int'(v0), 1);
        chk("stall_idx", int'(idx0), 5);
        r0 = 8'h80;
        tick();
        chk("stall_hold", int'(idx0), 5);
        chk("stall_pend", int'(p0), 8'h80);
        r0 = '0;
        tick();
        chk("stall_v_held", int'(v0), 1);
        chk("stall_idx_held", int'(idx0), 5);
        chk("stall_pend_held", int'(p0), 8'h80);
        rdy0 = 1'b1;
        tick();
        chk("stall_rel_idx", int'(idx0), 7);
        chk("stall_rel_pend", int'(p0), 0);
        tick();
        chk("stall_done_v", int'(v0), 0);
        chk("idx_kept_when_idle", int'(idx0), 7);

        // ---- re-request of the presented index becomes a new request
        rdy0 = 1'b0;
        r0 = 8'h08;
        q0.push_back(3); q0.push_back(3);
        tick();
        chk("same_idx", int'(idx0), 3);
        r0 = 8'h08;
        tick();
        chk("same_pend", int'(p0), 8'h08);
        r0 = '0;
        rdy0 = 1'b1;
        tick();
        chk("same_again", int'(idx0), 3);
        chk("same_again_v", int'(v0), 1);
        tick();
        chk("same_done", int'(v0), 0);

        // ---- continuous requests on 7 and 1
        for (int i = 0; i < 6; i++) q0.push_back(7);
        q0.push_back(1);
        for (int i = 0; i < 3; i++) begin q1.push_back(7); q1.push_back(1); end
        q1.push_back(7);
        for (int i = 0; i < 6; i++) begin
            r0 = 8'h82; r1 = 8'h82;
            tick();
        end
        r0 = '0; r1 = '0;
        tick(3);
        chk("cont_d0_idle", int'(v0), 0);
        chk("cont_d1_idle", int'(v1), 0);

        // ---- reset in the middle of a stall
        rdy0 = 1'b0;
        r0 = 8'h1F;
        tick();
        chk("mid_idx", int'(idx0), 4);
        chk("mid_pend", int'(p0), 8'h0F);
        r0 = '0;
        #2 rst = 1'b1;
        #1;
        chk("async_v", int'(v0), 0);
        chk("async_pend", int'(p0), 0);
        chk("async_idx", int'(idx0), 0);
        chk("async_busy", int'(b0), 0);
        #2 rst = 1'b0;
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_out", int'(v0), 0);
        end

        // ---- round-robin pointer restarts at N-1 after reset
        r1 = 8'h82;
        q1.push_back(7); q1.push_back(1);
        tick();
        chk("rr_rst_first", int'(idx1), 7);
        r1 = '0;
        tick();
        chk("rr_rst_second", int'(idx1), 1);
        tick();
        chk("rr_rst_idle", int'(v1), 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prio_req_encoder.md
PRIO_REQ_ENCODER -- requirements
Module: prio_req_encoder

Interface
REQ-001 Parameter N, default 8, number of request lines (N >= 2, need not be a power of two).
REQ-002 Parameter W, default $clog2(N), index width; it SHALL be derived, not overridden.
REQ-003 Parameter MODE, default 0, arbitration mode: 0 = fixed priority with the highest index winning, 1 = round-robin.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 req_in  input  N  request pulses; a 1 on bit i for one cycle SHALL register one request on line i.
REQ-007 out_ready  input  1  consumer accepts the presented index.
REQ-008 out_valid  output  1  out_idx holds a valid encoded request.
REQ-009 out_idx  output  W  encoded index of the presented request.
REQ-010 pending  output  N  registered requests that are not yet presented.
REQ-011 busy  output  1  equal to out_valid OR (|pending), combinational from registers.

Function
REQ-012 The candidate vector SHALL be cand = pending | req_in.
REQ-013 A load SHALL occur at a clock edge when (!out_valid || out_ready).
REQ-014 On a load with cand != 0, the block SHALL perform all of the following:
- out_valid <= 1
- out_idx <= sel(cand)
- pending <= cand & ~onehot(sel(cand))
REQ-015 On a load with cand == 0, the block SHALL set out_valid <= 0, leave out_idx unchanged, and keep pending at 0.
REQ-016 With no load (out_valid=1, out_ready=0), out_idx and out_valid SHALL hold, and pending SHALL update to pending | req_in.
REQ-017 Latency: a request arriving in cycle t with the output stage idle or accepting SHALL appear on out_valid/out_idx in cycle t+1.
REQ-018 In MODE=0, sel SHALL return the highest set index of cand.
REQ-019 In MODE=1, the round-robin search SHALL behave as follows:
- sel SHALL search descending from (last-1) mod N and wrap from 0 to N-1.
- "last" is a W-bit register that SHALL be updated to sel on every load with cand != 0.
- "last" SHALL be ignored in MODE=0.
REQ-020 A req_in bit equal to the index currently presented SHALL become a new pending request and SHALL NOT merge with the presented one.
REQ-021 A req_in bit already set in pending SHALL be absorbed; requests SHALL NOT count.
REQ-022 out_idx SHALL never exceed N-1, including when N is not a power of two.
REQ-023 A handshake (out_valid & out_ready) and a reload SHALL occur in the same edge, so back-to-back indices are issued at one per cycle.
REQ-024 out_valid SHALL NOT drop while out_ready=0.

Reset
REQ-025 While rst=1, the block SHALL immediately (asynchronously) drive out_valid=0, out_idx=0, pending=0 and last=0.
REQ-026 req_in asserted while rst=1 SHALL be discarded.
REQ-027 After rst deasserts, the first load in MODE=1 SHALL search from N-1, which matches MODE=0 ordering.
REQ-028 Reset asserted mid-stall SHALL discard the presented index and all pending requests, with no output after release until a new req_in.

Verification (N=8 unless stated)
REQ-029 MODE=0, out_ready=1, req_in=8'b0010_0100 for one cycle at t -> out_idx 5 at t+1, out_idx 2 at t+2, out_valid=0 at t+3, busy=0 at t+3.
REQ-030 MODE=0, out_idx=5 presented, out_ready=0 for 3 cycles, req_in=8'b1000_0000 during the stall:
- out_idx SHALL hold 5 with pending=8'b1000_0000.
- After out_ready=1, out_idx SHALL be 7 next cycle.
REQ-031 out_ready=1, req_in bits 7 and 1 asserted every cycle:
- MODE=0 -> out_idx 7,7,7,...
- MODE=1 -> out_idx 7,1,7,1,...
REQ-032 out_idx=3 presented and stalled, req_in=8'b0000_1000 -> pending=8'b0000_1000; after the handshake, out_idx SHALL be 3 again next cycle.
REQ-033 pending=8'h0F with out_valid=1, rst pulsed between clock edges:
- out_valid=0 and pending=0 SHALL be seen before the next edge.
- No output SHALL appear after release.
REQ-034 N=5 (W=3), MODE=1, req_in=5'b10001 once, out_ready=1 -> out_idx 4 then 0, then out_valid=0.
